// File: rtl/brevia_pkg.sv
// Shared constants and event-word layout for the Brevia switch conditioner.
package brevia_pkg;

    localparam int unsigned STABLE_CYCLES_DEF = 32'd4000000;
    localparam int unsigned CNT_W_DEF         = 32'd22;
    localparam logic [7:0]  RST_VAL_DEF       = 8'hFF;
    localparam int unsigned FIFO_DEPTH_DEF    = 32'd4;

    // Width needed to index n items, never less than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        if (n > 32'd1) begin
            return $clog2(n);
        end else begin
            return 32'd1;
        end
    endfunction

    // The edge flag (1 = rise) sits directly above the index field.
    function automatic int unsigned evt_edge_pos(input int unsigned n);
        return idx_w(n);
    endfunction

endpackage

// File: rtl/brevia_db_bit.sv
// One switch lane: 2-FF synchroniser, stability counter, debounced level
// register and one-cycle rise/fall pulses aligned with the level change.
module brevia_db_bit
    import brevia_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter logic        RST_VAL       = 1'b1
) (
    input  logic clk400,
    input  logic async_reset,
    input  logic sw_raw,
    output logic sw_db,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST_C = CNT_W'(STABLE_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(32'd1);

    logic             sync1_r;
    logic             sync2_r;
    logic             db_r;
    logic             rise_r;
    logic             fall_r;
    logic [CNT_W-1:0] cnt_r;

    // Bring the asynchronous pin into clk400; reset to the idle level so
    // reset release never looks like an edge.
    always_ff @(posedge clk400 or negedge async_reset) begin
        if (!async_reset) begin
            sync1_r <= RST_VAL;
            sync2_r <= RST_VAL;
        end else begin
            sync1_r <= sw_raw;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive disagreeing cycles; accept the new level once it has
    // held long enough and flag the direction for exactly that cycle.
    always_ff @(posedge clk400 or negedge async_reset) begin
        if (!async_reset) begin
            cnt_r  <= '0;
            db_r   <= RST_VAL;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            if (sync2_r == db_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST_C) begin
                cnt_r  <= '0;
                db_r   <= ~db_r;
                rise_r <= ~db_r;
                fall_r <= db_r;
            end else begin
                cnt_r <= cnt_r + CNT_ONE_C;
            end
        end
    end

    assign sw_db = db_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/brevia_sw_debounce.sv
// Debounces N_SW switch pins, emits edge pulses, and queues each edge as an
// {edge, index} event behind a valid/ready FIFO with a sticky drop flag.
module brevia_sw_debounce
    import brevia_pkg::*;
#(
    parameter int unsigned       N_SW          = 32'd8,
    parameter int unsigned       STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int unsigned       CNT_W         = CNT_W_DEF,
    parameter logic [N_SW-1:0]   RST_VAL       = N_SW'(RST_VAL_DEF),
    parameter int unsigned       FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
    input  logic                    clk400,
    input  logic                    async_reset,
    input  logic [N_SW-1:0]         sw_raw,
    output logic [N_SW-1:0]         sw_db,
    output logic [N_SW-1:0]         rise,
    output logic [N_SW-1:0]         fall,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [idx_w(N_SW):0]    evt_data,
    output logic                    ovf,
    input  logic                    ovf_clr
);

    localparam int unsigned IDX_W  = idx_w(N_SW);
    localparam int unsigned EVT_W  = IDX_W + 32'd1;
    localparam int unsigned PTR_W  = idx_w(FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 32'd1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE_C = (PTR_W + 32'd1)'(32'd1);
    localparam logic [PTR_W-1:0] PTR_ONE_C = PTR_W'(32'd1);

    logic [N_SW-1:0]  pending_r;
    logic [N_SW-1:0]  pend_edge_r;
    logic [N_SW-1:0]  edge_s;
    logic [N_SW-1:0]  eff_s;
    logic [N_SW-1:0]  eff_edge_s;
    logic [N_SW-1:0]  grant_s;
    logic [IDX_W-1:0] push_idx_s;
    logic             found_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             ovf_set_s;
    logic [EVT_W-1:0] push_data_s;

    logic [EVT_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [PTR_W:0]   count_nxt_s;
    logic [PTR_W:0]   count_after_pop_s;
    logic [PTR_W-1:0] rd_nxt_s;
    logic [EVT_W-1:0] head_nxt_s;
    logic             evt_valid_r;
    logic [EVT_W-1:0] evt_data_r;
    logic             ovf_r;

    for (genvar g = 0; g < N_SW; g++) begin : g_bit
        brevia_db_bit #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .CNT_W         (CNT_W),
            .RST_VAL       (RST_VAL[g])
        ) u_bit (
            .clk400        (clk400),
            .async_reset   (async_reset),
            .sw_raw        (sw_raw[g]),
            .sw_db         (sw_db[g]),
            .rise          (rise[g]),
            .fall          (fall[g])
        );
    end

    // A new edge only counts when its lane is free; an already pending edge
    // keeps its type and any colliding new edge is the one that gets dropped.
    always_comb begin
        edge_s     = rise | fall;
        eff_s      = pending_r | edge_s;
        eff_edge_s = (pending_r & pend_edge_r) | (~pending_r & rise);
        ovf_set_s  = |(edge_s & pending_r);
        full_s     = (count_r >= DEPTH_C);
    end

    // Fixed-priority arbiter: lowest pending index wins one push per cycle.
    always_comb begin
        found_s    = 1'b0;
        push_idx_s = '0;
        grant_s    = '0;
        for (int unsigned i = 0; i < N_SW; i++) begin
            if (eff_s[i] && !found_s) begin
                found_s    = 1'b1;
                push_idx_s = IDX_W'(i);
            end else begin
                found_s = found_s;
            end
        end
        push_s = found_s && !full_s;
        if (push_s) begin
            grant_s[push_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
        push_data_s = {eff_edge_s[push_idx_s], push_idx_s};
    end

    // Next FIFO occupancy and show-ahead head; an empty-after-pop queue takes
    // the word being pushed straight into the head register.
    always_comb begin
        pop_s             = evt_valid_r && evt_ready;
        count_after_pop_s = pop_s ? (count_r - CNT_ONE_C) : count_r;
        count_nxt_s       = push_s ? (count_after_pop_s + CNT_ONE_C) : count_after_pop_s;
        rd_nxt_s          = pop_s ? (rd_ptr_r + PTR_ONE_C) : rd_ptr_r;
        if (push_s && (count_after_pop_s == '0)) begin
            head_nxt_s = push_data_s;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Pending flags, their edge types and the sticky overflow flag.
    always_ff @(posedge clk400 or negedge async_reset) begin
        if (!async_reset) begin
            pending_r   <= '0;
            pend_edge_r <= '0;
            ovf_r       <= 1'b0;
        end else begin
            pending_r   <= eff_s & ~grant_s;
            pend_edge_r <= eff_edge_s;
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    // Event queue storage, pointers and registered head/valid.
    always_ff @(posedge clk400 or negedge async_reset) begin
        if (!async_reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            evt_valid_r <= 1'b0;
            evt_data_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE_C;
            end
            rd_ptr_r    <= rd_nxt_s;
            count_r     <= count_nxt_s;
            evt_valid_r <= (count_nxt_s != '0);
            evt_data_r  <= head_nxt_s;
        end
    end

    assign evt_valid = evt_valid_r;
    assign evt_data  = evt_data_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_brevia_sw_debounce.sv
// Directed bench for brevia_sw_debounce with STABLE_CYCLES = 4.
`timescale 1ns/1ps
module tb_brevia_sw_debounce;

    logic       clk400;
    logic       async_reset;
    logic [7:0] sw_raw;
    logic [7:0] sw_db;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_data;
    logic       ovf;
    logic       ovf_clr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    brevia_sw_debounce #(
        .N_SW          (8),
        .STABLE_CYCLES (4),
        .CNT_W         (3),
        .RST_VAL       (8'hFF),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk400      (clk400),
        .async_reset (async_reset),
        .sw_raw      (sw_raw),
        .sw_db       (sw_db),
        .rise        (rise),
        .fall        (fall),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_data    (evt_data),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr)
    );

    initial clk400 = 1'b0;
    always #5 clk400 = ~clk400;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk400);
    endtask

    initial begin
        logic [3:0] exp_q [5];

        async_reset = 1'b0;
        sw_raw      = 8'hFF;
        evt_ready   = 1'b0;
        ovf_clr     = 1'b0;
        cyc(3);
        chk("rst_sw_db", 32'(sw_db), 32'h0000_00FF);
        chk("rst_edges", 32'(rise | fall), 32'h0000_0000);
        chk("rst_valid", 32'(evt_valid), 32'h0000_0000);
        chk("rst_ovf", 32'(ovf), 32'h0000_0000);

        // Reset release: quiet for 20 cycles.
        async_reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("idle_sw_db", 32'(sw_db), 32'h0000_00FF);
            chk("idle_edges", 32'(rise | fall), 32'h0000_0000);
            chk("idle_valid", 32'(evt_valid), 32'h0000_0000);
        end

        // Bit 4 falls: level changes 6 cycles after the pin.
        sw_raw = 8'hEF;
        cyc(5);
        chk("b4_before", 32'(sw_db), 32'h0000_00FF);
        cyc(1);
        chk("b4_sw_db", 32'(sw_db), 32'h0000_00EF);
        chk("b4_fall", 32'(fall), 32'h0000_0010);
        chk("b4_valid_early", 32'(evt_valid), 32'h0000_0000);
        cyc(1);
        chk("b4_fall_end", 32'(fall), 32'h0000_0000);
        chk("b4_valid", 32'(evt_valid), 32'h0000_0001);
        chk("b4_data", 32'(evt_data), 32'h0000_0004);
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        chk("b4_popped", 32'(evt_valid), 32'h0000_0000);

        // Bit 4 rises back.
        sw_raw = 8'hFF;
        cyc(6);
        chk("b4r_rise", 32'(rise), 32'h0000_0010);
        cyc(1);
        chk("b4r_valid", 32'(evt_valid), 32'h0000_0001);
        chk("b4r_data", 32'(evt_data), 32'h0000_000C);
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        chk("b4r_popped", 32'(evt_valid), 32'h0000_0000);

        // Bit 0 glitch of 3 cycles: no change, no event.
        sw_raw = 8'hFE;
        cyc(3);
        sw_raw = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("glitch_sw_db", 32'(sw_db), 32'h0000_00FF);
            chk("glitch_edges", 32'(rise | fall), 32'h0000_0000);
            chk("glitch_valid", 32'(evt_valid), 32'h0000_0000);
        end

        // All bits fall together with the consumer stalled.
        sw_raw = 8'h00;
        cyc(6);
        chk("all_fall", 32'(fall), 32'h0000_00FF);
        chk("all_sw_db", 32'(sw_db), 32'h0000_0000);
        cyc(1);
        chk("all_valid", 32'(evt_valid), 32'h0000_0001);
        chk("all_head", 32'(evt_data), 32'h0000_0000);
        cyc(4);
        chk("all_stall_valid", 32'(evt_valid), 32'h0000_0001);
        chk("all_stall_head", 32'(evt_data), 32'h0000_0000);
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", 32'(evt_valid), 32'h0000_0001);
            chk("drain_data", 32'(evt_data), 32'(i));
            cyc(1);
        end
        chk("drain_empty", 32'(evt_valid), 32'h0000_0000);
        chk("drain_ovf", 32'(ovf), 32'h0000_0000);
        evt_ready = 1'b0;

        // Fill the queue with rises on bits 4..7, then bit 2 rises and falls.
        sw_raw = 8'hF0;
        cyc(10);
        chk("fill_valid", 32'(evt_valid), 32'h0000_0001);
        chk("fill_head", 32'(evt_data), 32'h0000_000C);
        sw_raw = 8'hF4;
        cyc(6);
        chk("b2_rise", 32'(rise), 32'h0000_0004);
        chk("b2_ovf0", 32'(ovf), 32'h0000_0000);
        sw_raw = 8'hF0;
        cyc(6);
        chk("b2_fall", 32'(fall), 32'h0000_0004);
        chk("b2_ovf_pre", 32'(ovf), 32'h0000_0000);
        cyc(1);
        chk("b2_ovf_set", 32'(ovf), 32'h0000_0001);
        chk("b2_head", 32'(evt_data), 32'h0000_000C);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        chk("b2_ovf_clr", 32'(ovf), 32'h0000_0000);

        // Drain: four rises from bits 4..7, then the kept rise on bit 2.
        exp_q[0] = 4'hC;
        exp_q[1] = 4'hD;
        exp_q[2] = 4'hE;
        exp_q[3] = 4'hF;
        exp_q[4] = 4'hA;
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("ovf_drain_valid", 32'(evt_valid), 32'h0000_0001);
            chk("ovf_drain_data", 32'(evt_data), 32'(exp_q[i]));
            cyc(1);
        end
        chk("ovf_drain_empty", 32'(evt_valid), 32'h0000_0000);
        evt_ready = 1'b0;

        // Three events queued, then asynchronous reset.
        sw_raw = 8'h10;
        cyc(10);
        chk("pre_rst_valid", 32'(evt_valid), 32'h0000_0001);
        chk("pre_rst_head", 32'(evt_data), 32'h0000_0005);
        async_reset = 1'b0;
        sw_raw      = 8'hFF;
        #1;
        chk("rst_async_valid", 32'(evt_valid), 32'h0000_0000);
        chk("rst_async_sw_db", 32'(sw_db), 32'h0000_00FF);
        cyc(2);
        async_reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("post_rst_valid", 32'(evt_valid), 32'h0000_0000);
            chk("post_rst_sw_db", 32'(sw_db), 32'h0000_00FF);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/brevia_sw_debounce.md
# brevia_sw_debounce

Input-side conditioner for the Brevia board's DIP switches and push buttons (sw[7:0]). It synchronises each raw pin into clk400, debounces it, and emits one-cycle rise/fall pulses. Each edge is also queued as an event word behind a valid/ready handshake, so control logic can consume clean button presses instead of sampling raw pins.

## Interface
Parameters:
- N_SW, 8, number of switch inputs (index width IDX_W = $clog2(N_SW), minimum 1)
- STABLE_CYCLES, 4_000_000, consecutive cycles a new level must hold before acceptance (10 ms at 400 MHz)
- CNT_W, 22, debounce counter width; must satisfy 2^CNT_W > STABLE_CYCLES
- RST_VAL, 8'hFF, debounced level after reset (buttons are active-low, released = 1)
- FIFO_DEPTH, 4, event queue depth (power of 2)

Ports:
- clk400  input  1  400 MHz system clock from PLL CLKOP
- async_reset  input  1  asynchronous, active-low reset
- sw_raw  input  N_SW  raw pins, asynchronous to clk400
- sw_db  output  N_SW  debounced levels
- rise  output  N_SW  one-cycle pulse per bit on debounced 0→1
- fall  output  N_SW  one-cycle pulse per bit on debounced 1→0
- evt_valid  output  1  event queue non-empty
- evt_ready  input  1  consumer accepts the head event
- evt_data  output  1+IDX_W  {edge (1 = rise), index}, show-ahead
- ovf  output  1  sticky flag: an event was dropped
- ovf_clr  input  1  clears ovf

## Operation
- Per bit: 2-FF synchroniser, then counter cnt. When sync == sw_db, cnt = 0. Otherwise cnt increments; on the cycle cnt reaches STABLE_CYCLES-1, sw_db toggles and cnt returns to 0.
- A glitch shorter than STABLE_CYCLES resets cnt and produces no change.
- A sw_db toggle asserts rise[i] or fall[i] for exactly that first cycle and sets pending[i] with its edge type.
- If pending[i] is already set when a new edge on bit i occurs: the new edge is dropped, the old pending is kept, and ovf is set.
- Arbiter: each cycle, if the FIFO is not full (registered count < FIFO_DEPTH), the lowest-index pending bit is pushed and its pending flag is cleared. Only one push per cycle.
- FIFO: pop when evt_valid && evt_ready. Push and pop in the same cycle leave the count unchanged. Push is blocked only by registered full; a pop in the same cycle does not unblock it.
- ovf_clr and a new overflow in the same cycle: set wins.
- Reset values: sw_db = RST_VAL; rise, fall, pending, cnt, FIFO count/pointers = 0; evt_valid = 0; ovf = 0; synchroniser FFs = RST_VAL, so releasing reset generates no spurious edge.
- Reset mid-operation discards all queued and pending events.

## Timing
- sw_raw change to sw_db change: 2 (sync) + STABLE_CYCLES cycles.
- Edge cycle T: rise/fall high and pending set in T. The push occurs at the end of T if not full, giving evt_valid in T+1 when the queue was empty.
- With all N_SW bits pending simultaneously and an empty FIFO, the bits enter the queue in ascending index order, one per cycle. The bits beyond FIFO_DEPTH wait in pending and are not lost.
- evt_data and evt_valid are registered; evt_ready is sampled combinationally only for the pop decision.

## Structure
- Package brevia_pkg holds the default constants (STABLE_CYCLES, RST_VAL, FIFO_DEPTH) and the event field layout (EDGE bit position, IDX_W function).
- Sub-module brevia_db_bit (synchroniser, counter, level register, edge pulses), instantiated N_SW times by generate.
- The arbiter and FIFO stay in the top level.

## Test plan
All scenarios use STABLE_CYCLES = 4.
- Reset release with sw_raw = 8'hFF → sw_db = 8'hFF, no rise/fall pulses, evt_valid = 0 for 20 cycles.
- sw_raw[4] held 1→0 → sw_db[4] falls exactly 6 cycles later, fall[4] pulses for 1 cycle, then evt_data = {0, 3'd4} with evt_valid high on the next cycle.
- sw_raw[0] low for 3 cycles then high → no sw_db change and no event.
- sw_raw[7:0] all fall in the same cycle with evt_ready = 0 → events for indices 0..3 are queued, 4..7 stay pending. Then evt_ready = 1 → events pop in index order 0..7, ovf stays 0.
- Bit 2 toggles 0→1→0 (each level held 6 cycles) with a full FIFO and evt_ready = 0 → the first edge stays pending, the second is dropped, ovf = 1. An ovf_clr pulse → ovf = 0.
- Assert async_reset with 3 events queued → evt_valid = 0 immediately, queue empty after release.
